// File: rtl/prog_sync_fifo.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, occupancy count,
// sticky overflow/underflow flags and a registered or first-word-fall-through read port.
module prog_sync_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     r_en,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (WIDTH < 1 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 ||
      AE_LEVEL < 1 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
    $fatal(1, "prog_sync_fifo: illegal parameter combination");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q;
  logic             wr_acc, rd_acc;

  // Flags decode only the registered count, so w_en/r_en never reach them combinationally.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;

  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      if (wr_acc && !rd_acc)      count_q <= count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_q <= count_q - CW'(1);
    end
  end

  // Set beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (w_en && full)  overflow <= 1'b1;
      else if (err_clr)  overflow <= 1'b0;
      if (r_en && empty) underflow <= 1'b1;
      else if (err_clr)  underflow <= 1'b0;
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign data_out = mem[rd_ptr];
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)         dout_q <= '0;
      else if (rd_acc) dout_q <= mem[rd_ptr];
    end
    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_prog_sync_fifo.sv
// Scoreboard bench: a registered-read instance for most scenarios plus an FWFT instance.
module tb_prog_sync_fifo;
  localparam int W = 8;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // registered-read DUT
  logic w_en = 0, r_en = 0, err_clr = 0;
  logic [W-1:0] data_in = '0, data_out;
  logic full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  // FWFT DUT
  logic w2 = 0, r2 = 0;
  logic [W-1:0] d2 = '0, q2;
  logic full2, empty2, af2, ae2, ov2, un2;
  logic [4:0] cnt2;

  prog_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr));

  prog_sync_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .w_en(w2), .data_in(d2), .r_en(r2),
    .data_out(q2), .full(full2), .empty(empty2), .almost_full(af2),
    .almost_empty(ae2), .count(cnt2), .overflow(ov2),
    .underflow(un2), .err_clr(1'b0));

  int tests = 0, fails = 0;
  logic [W-1:0] sb[$], sb2[$];
  int mcnt = 0, mcnt2 = 0;
  logic mov = 0, mun = 0;
  logic [W-1:0] mdout = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("count", count, mcnt);
    chk("full", full, mcnt == D);
    chk("empty", empty, mcnt == 0);
    chk("almost_full", almost_full, mcnt >= D - 2);
    chk("almost_empty", almost_empty, mcnt <= 2);
    chk("overflow", overflow, mov);
    chk("underflow", underflow, mun);
    chk("data_out", data_out, mdout);
  endtask

  // One clock on the registered DUT; the model decides acceptance from its own state.
  task automatic cyc(input logic w, input logic [W-1:0] d, input logic r, input logic ec);
    logic wa, ra;
    w_en = w; data_in = d; r_en = r; err_clr = ec;
    @(posedge clk);
    wa = w && (mcnt != D);
    ra = r && (mcnt != 0);
    if (w && mcnt == D) mov = 1; else if (ec) mov = 0;
    if (r && mcnt == 0) mun = 1; else if (ec) mun = 0;
    if (ra) mdout = sb.pop_front();
    if (wa) sb.push_back(d);
    mcnt = mcnt + int'(wa) - int'(ra);
    #1;
    w_en = 0; r_en = 0; err_clr = 0;
    chk_state();
  endtask

  task automatic cyc2(input logic w, input logic [W-1:0] d, input logic r);
    logic wa, ra;
    w2 = w; d2 = d; r2 = r;
    @(posedge clk);
    wa = w && (mcnt2 != D);
    ra = r && (mcnt2 != 0);
    if (ra) void'(sb2.pop_front());
    if (wa) sb2.push_back(d);
    mcnt2 = mcnt2 + int'(wa) - int'(ra);
    #1;
    w2 = 0; r2 = 0;
    chk("fwft_count", cnt2, mcnt2);
    chk("fwft_empty", empty2, mcnt2 == 0);
    if (mcnt2 != 0) chk("fwft_head", q2, sb2[0]);
  endtask

  task automatic model_reset();
    sb.delete(); sb2.delete();
    mcnt = 0; mcnt2 = 0; mov = 0; mun = 0; mdout = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    #1 chk_state();
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    // reset values while rst is held
    #2 chk_state();
    chk("fwft_empty_rst", empty2, 1);
    @(posedge clk); #1 rst = 0;

    // mid-stream reset at count=5 with nonzero data_out
    for (int i = 0; i < 6; i++) cyc(1, W'(8'h11 + i), 0, 0);
    cyc(0, '0, 1, 0);
    chk("pre_reset_count", count, 5);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, W'(8'h70 + i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, '0, 1, 0);

    // fill 0x00..0x0F, thresholds, drain in order
    for (int i = 0; i < D; i++) cyc(1, W'(i), 0, 0);
    chk("filled_full", full, 1);
    for (int i = 0; i < D; i++) cyc(0, '0, 1, 0);
    chk("drained_empty", empty, 1);

    // full with simultaneous read/write: write dropped, overflow set
    for (int i = 0; i < D; i++) cyc(1, W'(8'h40 + i), 0, 0);
    cyc(1, 8'hEE, 1, 0);
    chk("ovf_count", count, 15);
    cyc(0, '0, 0, 1);
    for (int i = 0; i < D - 1; i++) cyc(0, '0, 1, 0);

    // empty with simultaneous read/write: write taken, underflow set
    cyc(1, 8'hA5, 1, 0);
    chk("unf_count", count, 1);
    cyc(0, '0, 1, 0);
    chk("unf_data", data_out, 8'hA5);
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 1);

    // set wins over coincident clear
    cyc(0, '0, 1, 1);
    cyc(0, '0, 0, 1);

    // steady state at count=8 with pointer wrap
    for (int i = 0; i < 8; i++) cyc(1, W'($urandom_range(0, 255)), 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, W'($urandom_range(0, 255)), 1, 0);
    chk("steady_count", count, 8);
    for (int i = 0; i < 8; i++) cyc(0, '0, 1, 0);

    // FWFT: head visible the cycle after its write
    cyc2(1, 8'h3C, 0);
    chk("fwft_first", q2, 8'h3C);
    cyc2(0, '0, 1);
    chk("fwft_empty_after", empty2, 1);
    for (int i = 0; i < 5; i++) cyc2(1, W'(8'h90 + i), 0);
    for (int i = 0; i < 4; i++) cyc2(1, W'(8'hC0 + i), 1);
    for (int i = 0; i < 5; i++) cyc2(0, '0, 1);
    chk("fwft_ov_un", {ov2, un2}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
